// File: rtl/branch_predict_resolve_unit.sv
// ============================================================================
// branch_predict_resolve_unit
//
// Purpose:
//   Branch target buffer (BTB) with 2-bit saturating direction counters,
//   combined with EX-stage branch resolution and mispredict detection.
//   The IF stage looks up the fetch PC with zero latency.  The EX stage
//   resolves beq / bgt / unconditional / ret, compares the outcome with the
//   prediction carried down the pipe, and requests a redirect on mismatch.
//   The table is written on the clock edge that ends a resolution cycle.
//
// Optional feature (compile-time macro BRANCH_STATS_EN):
//   When defined, adds 32-bit wrapping counters stat_branches and
//   stat_mispredicts as extra output ports.  When undefined, those ports
//   and counters do not exist.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   if_pc               fetch PC to look up
//   if_pred_taken       predicted direction for if_pc
//   if_pred_target      predicted next PC (if_pc+4 when not predicted taken)
//   ex_valid, ex_stall  EX holds a real instruction / EX is held this cycle
//   ex_pc               PC of the EX instruction
//   ex_isBeq/Bgt/Ubranch/Ret  decoded control bits
//   ex_flags            [0]=eq, [1]=gt
//   ex_branchTarget     computed immediate target
//   ex_opA              return address used by ret
//   ex_pred_taken/target  prediction made in IF for this instruction
//   ex_branch_taken     resolved direction
//   ex_branchPC         resolved target (ex_opA for ret, else ex_branchTarget)
//   ex_mispredict       pipeline flush request
//   ex_redirect_pc      correct next PC
//   stat_branches, stat_mispredicts  (BRANCH_STATS_EN only)
// ============================================================================
module branch_predict_resolve_unit #(
  parameter int         PC_W     = 32,
  parameter int         IDX_BITS = 4,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [PC_W-1:0] if_pred_target,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_isBeq,
  input  logic            ex_isBgt,
  input  logic            ex_isUbranch,
  input  logic            ex_isRet,
  input  logic [1:0]      ex_flags,
  input  logic [PC_W-1:0] ex_branchTarget,
  input  logic [PC_W-1:0] ex_opA,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pred_target,
  output logic            ex_branch_taken,
  output logic [PC_W-1:0] ex_branchPC,
  output logic            ex_mispredict,
  output logic [PC_W-1:0] ex_redirect_pc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam int TAG_W = PC_W - IDX_BITS - 2;

  // Table storage: valid and counters are reset, tags/targets are not.
  logic             valid_q  [DEPTH];
  logic [1:0]       ctr_q    [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [PC_W-1:0]  target_q [DEPTH];

  logic [IDX_BITS-1:0] if_idx;
  logic [TAG_W-1:0]    if_tag;
  logic                if_hit;
  logic [IDX_BITS-1:0] ex_idx;
  logic [TAG_W-1:0]    ex_tag;
  logic                ex_hit;
  logic                is_cond;
  logic                br;
  logic                upd_en;

  logic       alloc_en;
  logic       inval_en;
  logic       ctr_en;
  logic [1:0] ctr_val;
  logic [1:0] ctr_cur;

  // Word-alignment bits never reach the table; named so lint treats them as intentionally unused.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_BITS+2];

  // IF-side lookup reads registered table state, so a same-cycle update at
  // the same index is only seen from the following cycle onwards.
  always_comb begin
    if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    if_pred_taken  = if_hit && ctr_q[if_idx][1];
    if_pred_target = if_pred_taken ? target_q[if_idx] : (if_pc + PC_W'(4));
  end

  // EX-side resolution.  A non-branch that arrived with a taken prediction
  // is caught by the direction mismatch term and redirected to ex_pc+4.
  always_comb begin
    is_cond         = ex_isBeq | ex_isBgt;
    br              = ex_valid && (is_cond | ex_isUbranch | ex_isRet);
    ex_branch_taken = ex_valid && ((ex_isBeq & ex_flags[0]) | (ex_isBgt & ex_flags[1]) |
                                   ex_isUbranch | ex_isRet);
    ex_branchPC     = ex_isRet ? ex_opA : ex_branchTarget;
    ex_mispredict   = ex_valid && !ex_stall &&
                      ((ex_branch_taken != ex_pred_taken) ||
                       (ex_branch_taken && (ex_pred_target != ex_branchPC)));
    ex_redirect_pc  = ex_branch_taken ? ex_branchPC : (ex_pc + PC_W'(4));
    ex_hit          = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    upd_en          = br && !ex_stall;
  end

  // Decide what the resolving instruction does to its table entry.  Ret is
  // deliberately never learned; a non-branch that hit an entry is a stale
  // alias and invalidates it.  Priority ret > unconditional > conditional.
  always_comb begin
    alloc_en = 1'b0;
    inval_en = 1'b0;
    ctr_en   = 1'b0;
    ctr_cur  = ctr_q[ex_idx];
    ctr_val  = ctr_cur;
    if (ex_valid && !ex_stall) begin
      if (ex_isRet) begin
        alloc_en = 1'b0;
      end else if (ex_isUbranch) begin
        alloc_en = 1'b1;
        ctr_en   = 1'b1;
        ctr_val  = 2'b11;
      end else if (is_cond) begin
        if (ex_hit) begin
          ctr_en = 1'b1;
          if (ex_branch_taken) begin
            ctr_val = (ctr_cur == 2'b11) ? 2'b11 : (ctr_cur + 2'd1);
          end else begin
            ctr_val = (ctr_cur == 2'b00) ? 2'b00 : (ctr_cur - 2'd1);
          end
        end else if (ex_branch_taken) begin
          alloc_en = 1'b1;
          ctr_en   = 1'b1;
          ctr_val  = 2'b10;
        end
      end else if (ex_hit) begin
        inval_en = 1'b1;
      end
    end
  end

  // Valid bits and counters: cleared asynchronously so that lookups miss
  // the moment reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else begin
      if (alloc_en) begin
        valid_q[ex_idx] <= 1'b1;
      end else if (inval_en) begin
        valid_q[ex_idx] <= 1'b0;
      end
      if (ctr_en) begin
        ctr_q[ex_idx] <= ctr_val;
      end
    end
  end

  // Tag and target payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (alloc_en) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= ex_branchTarget;
    end
  end

`ifdef BRANCH_STATS_EN
  // Event counters: resolved branches that update the table, and flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (upd_en) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (ex_mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end
`else
  logic unused_upd_en;
  assign unused_upd_en = upd_en;
`endif

endmodule

// File: doc/branch_predict_resolve_unit.md
Name: branch_predict_resolve_unit

Overview:
- Next-generation branch unit: a PC-indexed branch target buffer (BTB) with 2-bit saturating counters, plus EX-stage branch resolution.
- IF stage looks up the fetch PC and gets a taken/not-taken prediction and a predicted target.
- EX stage resolves the branch as beq/bgt/unconditional/ret using the flags, compares the result with the prediction carried down the pipe, and raises a mispredict redirect.
- The table is updated sequentially at resolution.

Parameters:
- PC_W, 32: PC and target width.
- IDX_BITS, 4: BTB index bits; depth = 2**IDX_BITS entries.
- CTR_INIT, 2'b01: reset value of every counter (weakly not-taken).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  PC_W  fetch PC to look up.
- if_pred_taken  out  1  prediction for if_pc.
- if_pred_target  out  PC_W  predicted target; if_pc+4 when not predicted taken.
- ex_valid  in  1  a real instruction is in EX this cycle.
- ex_stall  in  1  EX held; suppresses the table update.
- ex_pc  in  PC_W  PC of the EX instruction.
- ex_isBeq, ex_isBgt, ex_isUbranch, ex_isRet  in  1 each  decoded control bits.
- ex_flags  in  2  [0]=eq, [1]=gt.
- ex_branchTarget  in  PC_W  computed immediate target.
- ex_opA  in  PC_W  return address for ret.
- ex_pred_taken  in  1  prediction made in IF, carried down the pipe.
- ex_pred_target  in  PC_W  target predicted in IF, carried down the pipe.
- ex_branch_taken  out  1  resolved direction.
- ex_branchPC  out  PC_W  resolved target: ex_opA if ex_isRet, else ex_branchTarget.
- ex_mispredict  out  1  pipeline flush request.
- ex_redirect_pc  out  PC_W  correct next PC.

Behaviour:
- Field split: idx = pc[IDX_BITS+1:2]; tag = pc[PC_W-1:IDX_BITS+2].
- Each entry holds valid, tag, target and a 2-bit counter.
- Reset (async, rst_n=0):
  - all valid bits cleared;
  - all counters = CTR_INIT;
  - tags and targets are don't-care;
  - optional stats counters = 0.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag match;
  - if_pred_taken = hit && ctr[idx][1];
  - if_pred_target = if_pred_taken ? target[idx] : if_pc+4, computed modulo 2**PC_W.
- Resolution (combinational):
  - br = ex_valid && (ex_isBeq | ex_isBgt | ex_isUbranch | ex_isRet);
  - ex_branch_taken = ex_valid && ((ex_isBeq&ex_flags[0]) | (ex_isBgt&ex_flags[1]) | ex_isUbranch | ex_isRet).
- Mispredict rule:
  - ex_mispredict = ex_valid && !ex_stall && ((ex_branch_taken != ex_pred_taken) || (ex_branch_taken && ex_pred_target != ex_branchPC));
  - a non-branch that was predicted taken (stale alias) also mispredicts;
  - ex_redirect_pc = ex_branch_taken ? ex_branchPC : ex_pc+4.
- Update, on posedge clk, only when br && !ex_stall:
  - Conditional (beq/bgt): taken makes ctr saturate-increment to max 3; not taken makes it saturate-decrement to min 0.
  - Conditional with no hit: allocate the entry only if taken, writing tag, target=ex_branchTarget and ctr=2'b10.
  - Unconditional: write tag, target and ctr=2'b11.
  - Ret: never allocated and counters untouched, so ret always redirects unless the predicted target happens to match.
  - Non-branch that hit (alias): clear valid[idx].
- Simultaneous lookup and update of the same idx: lookup returns the pre-update contents; the new value is visible the next cycle.
- An ex_stall cycle is idempotent. The unit holds no state other than the table, so a stalled EX instruction updates exactly once, in the cycle it unstalls.
- Reset asserted mid-operation clears the table immediately; outputs follow the combinational rules from the cleared state.

Optional Feature:
- BRANCH_STATS_EN defined:
  - adds outputs stat_branches[31:0] and stat_mispredicts[31:0];
  - each increments on the update condition (br && !ex_stall), and respectively on ex_mispredict;
  - counters wrap at 2**32 and reset to 0.
- Not defined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Cold after reset: if_pc=0x100 -> if_pred_taken=0, if_pred_target=0x104. Taken unconditional at ex_pc=0x100, target 0x200, pred_taken=0 -> ex_mispredict=1, redirect 0x200. Next cycle lookup 0x100 -> taken, target 0x200.
- Beq at 0x40, target 0x80, flags=01, taken three times, then flags=00 -> counter 10->11->11->10. Prediction stays taken. The fourth resolution mispredicts with redirect 0x44.
- Ret at 0x60, ex_opA=0x1234, pred_taken=0 -> ex_branchPC=0x1234, mispredict=1, no BTB entry created.
- Same-cycle lookup and update of idx 5 -> lookup returns the old entry. ex_stall=1 on a taken branch -> ex_mispredict=0 and no table change.
- Aliasing: entries at 0x0 and 0x400 with IDX_BITS=4 -> tag mismatch gives no hit. rst_n pulsed low mid-stream -> all lookups miss immediately.
- BRANCH_STATS_EN: 10 branches with 3 mispredicts -> stat_branches=10, stat_mispredicts=3.
